// File: rtl/rr_mux_pkg.sv
// Shared types and sizing helpers for the round-robin mux arbiter.
package rr_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int num_req(input int sel_w);
        return 1 << sel_w;
    endfunction

    // Wide enough to hold MAX_HOLD-1 for every MAX_HOLD >= 1.
    function automatic int hold_w(input int max_hold);
        return $clog2(max_hold) + 1;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating priority encoder: first set req bit at or above ptr, wrapping at N.
module rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared N:1 bit mux, with bounded grant length.
// Define RR_MUX_OUT_REG_EN to register valid/data_out (one extra cycle of latency).
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [num_req(SEL_W)-1:0] req,
    input  logic [num_req(SEL_W)-1:0] data_in,
    output logic [num_req(SEL_W)-1:0] gnt,
    output logic [SEL_W-1:0]          sel,
    output logic                      valid,
    output logic                      data_out
);

    localparam int N      = num_req(SEL_W);
    localparam int HOLD_W = hold_w(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_n;
    logic [SEL_W-1:0]  ptr, ptr_n, sel_n, pick_ptr, pick_idx;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [N-1:0]      gnt_n;
    logic              pick_found, valid_c, data_c;

    // While busy the search starts just past the current owner so a release
    // hands over without an idle bubble.
    assign pick_ptr = (state == BUSY) ? sel + SEL_W'(1) : ptr;

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // NOTE: state registers use non-blocking assignments so all regs update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            sel      <= sel_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        sel_n   = sel;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = BUSY;
                    gnt_n   = N'(1) << pick_idx;
                    sel_n   = pick_idx;
                    hold_n  = '0;
                end
            end
            BUSY: begin
                if (req[sel] && hold_cnt < HOLD_LAST) begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end else begin
                    ptr_n  = pick_ptr;
                    hold_n = '0;
                    if (pick_found) begin
                        gnt_n = N'(1) << pick_idx;
                        sel_n = pick_idx;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign valid_c = (state == BUSY) && req[sel];
    assign data_c  = valid_c && data_in[sel];

`ifdef RR_MUX_OUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            data_out <= 1'b0;
        end else begin
            valid    <= valid_c;
            data_out <= data_c;
        end
    end
`else
    assign valid    = valid_c;
    assign data_out = data_c;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter against a queue-free ownership model.
module tb_rr_mux_arbiter;

    localparam int SEL_W    = 2;
    localparam int MAX_HOLD = 4;
    localparam int N        = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   data_in = '0;
    logic [N-1:0]   gnt;
    logic [SEL_W-1:0] sel;
    logic           valid, data_out;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the channel, how many cycles it has held it,
    // and where the next round-robin search starts.
    int owner    = -1;
    int run_len  = 0;
    int rr_start = 0;
    int last_sel = 0;
    logic reg_valid = 1'b0;
    logic reg_data  = 1'b0;

    rr_mux_arbiter #(.SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .sel      (sel),
        .valid    (valid),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic model_valid(input logic [N-1:0] r);
        return (owner >= 0) && r[owner];
    endfunction

    function automatic logic model_data(input logic [N-1:0] r, input logic [N-1:0] d);
        return (owner >= 0) && r[owner] && d[owner];
    endfunction

    task automatic model_reset();
        owner = -1; run_len = 0; rr_start = 0; last_sel = 0;
        reg_valid = 1'b0; reg_data = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d);
        int nxt;
        reg_valid = model_valid(r);
        reg_data  = model_data(r, d);
        if (owner >= 0 && r[owner] && run_len < MAX_HOLD) begin
            run_len++;
        end else begin
            if (owner >= 0) rr_start = (owner + 1) % N;
            nxt = first_from(r, rr_start);
            owner = nxt;
            if (nxt >= 0) begin
                run_len  = 1;
                last_sel = nxt;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] exp_gnt;
        logic exp_v, exp_d;
        exp_gnt = (owner >= 0) ? (N'(1) << owner) : '0;
`ifdef RR_MUX_OUT_REG_EN
        exp_v = reg_valid;
        exp_d = reg_data;
`else
        exp_v = model_valid(req);
        exp_d = model_data(req, data_in);
`endif
        check({tag, ".gnt"},      32'(gnt),      32'(exp_gnt));
        check({tag, ".sel"},      32'(sel),      32'(last_sel));
        check({tag, ".valid"},    32'(valid),    32'(exp_v));
        check({tag, ".data_out"}, 32'(data_out), 32'(exp_d));
    endtask

    // Called just after a rising edge: drive, check at the falling edge, then advance.
    task automatic do_cycle(input string tag, input logic [N-1:0] r, input logic [N-1:0] d);
        req = r;
        data_in = d;
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, ".gnt"},      32'(gnt),      32'h0);
        check({tag, ".sel"},      32'(sel),      32'h0);
        check({tag, ".valid"},    32'(valid),    32'h0);
        check({tag, ".data_out"}, 32'(data_out), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;

        // 1: reset held with every requester active
        req = 4'b1111; data_in = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold.gnt",      32'(gnt),      32'h0);
        check("rst_hold.sel",      32'(sel),      32'h0);
        check("rst_hold.valid",    32'(valid),    32'h0);
        check("rst_hold.data_out", 32'(data_out), 32'h0);
        req = '0;
        do_reset("rst1");

        // 2: lone requester, re-granted on expiry, data tracks data_in[2]
        for (int i = 0; i < 10; i++) do_cycle("single", 4'b0100, N'($urandom));
        check("single.ptr_after", 32'(gnt), 32'h4);

        // 3: all requesting from ptr=0, four cycles each
        req = '0;
        do_reset("rst3");
        for (int i = 0; i < 20; i++) do_cycle("all_req", 4'b1111, N'($urandom));

        // 4: owner drops request, valid falls at once, grant moves next edge
        req = '0;
        do_reset("rst4");
        do_cycle("drop.a", 4'b0010, 4'b1111);
        do_cycle("drop.b", 4'b1010, 4'b1111);
        check("drop.gnt1", 32'(gnt), 32'h2);
        do_cycle("drop.c", 4'b1000, 4'b1111);
        check("drop.gnt3", 32'(gnt), 32'h8);
        check("drop.sel3", 32'(sel), 32'h3);

        // 5: reset mid-grant, next grant from ptr=0
        do_cycle("mid.a", 4'b1000, 4'b0000);
        req = 4'b1010;
        do_reset("mid_rst");
        do_cycle("mid.b", 4'b1010, 4'b0010);
        check("mid.gnt", 32'(gnt), 32'h2);

        // Random traffic with requests that persist a few cycles
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) r = N'($urandom);
            do_cycle("rand", r, N'($urandom));
            if (i == 200) begin
                req = r;
                do_reset("rand_rst");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
